// File: rtl/cla_mod_sub_pipe_if.sv
// -----------------------------------------------------------------------------
// cla_mod_sub_pipe_if
//   Streaming bundle for the pipelined modular subtractor: the operand side
//   (valid/ready plus a_in/b_in) and the result side (valid/ready plus
//   diff_out/out_err).
//
//   Signals
//     in_valid   operand pair on a_in/b_in is valid
//     in_ready   subtractor accepts a pair this cycle
//     a_in       minuend, WIDTH bits
//     b_in       subtrahend, WIDTH bits
//     out_valid  diff_out/out_err valid
//     out_ready  downstream accepts the result this cycle
//     diff_out   (a_in - b_in) mod MODULUS
//     out_err    operand range flag (0 unless the range check is built in)
//
//   Modports
//     master  the side that produces operands and consumes results
//     slave   the subtractor itself
// -----------------------------------------------------------------------------
interface cla_mod_sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff_out;
  logic             out_err;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, diff_out, out_err
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, diff_out, out_err
  );
endinterface

// File: rtl/cla_mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// cla_mod_sub_pipe
//   Pipelined modular subtractor: diff_out = (a_in - b_in) mod MODULUS for
//   operands in [0, MODULUS). Two register stages:
//     stage 1  raw = a_in + ~b_in + 1, brw = no carry out (a_in < b_in)
//     stage 2  diff = brw ? raw + MODULUS : raw   (mod 2**WIDTH)
//   Both adders are grouped carry-lookahead adders (GROUP bits per group,
//   group carries rippled between groups; the last group may be narrower).
//
//   Ports
//     clk   clock, rising edge
//     rst   synchronous active-high reset; clears both valids and diff_out
//     bus   cla_mod_sub_pipe_if.slave streaming bundle
//
//   Flow control: adv = !out_valid | out_ready moves the whole pipe; in_ready
//   is adv. Empty slots are not squeezed out, they move with the pipe.
//
//   Build option MODSUB_RANGE_CHK_EN: when defined, stage 1 also registers
//   (a_in >= MODULUS) | (b_in >= MODULUS) and the flag travels with its
//   result to out_err. When undefined, out_err is tied low.
// -----------------------------------------------------------------------------

// Grouped carry-lookahead adder: sum = x + y + cin.
module cla_mod_sub_pipe_cla #(
  parameter int WIDTH = 16,
  parameter int GROUP = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LO = gi * GROUP;
      localparam int GW = ((WIDTH - LO) < GROUP) ? (WIDTH - LO) : GROUP;

      logic [GW-1:0] bit_g;
      logic [GW-1:0] bit_p;
      logic [GW-1:0] bit_c;
      logic          g_acc;
      logic          p_acc;
      logic          c_run;

      assign bit_g = x[LO +: GW] & y[LO +: GW];
      assign bit_p = x[LO +: GW] ^ y[LO +: GW];

      // Group generate/propagate depend only on the operands, so the
      // inter-group carry chain never waits on carries inside a group.
      always_comb begin
        g_acc = 1'b0;
        p_acc = 1'b1;
        for (int k = 0; k < GW; k++) begin
          g_acc = bit_g[k] | (bit_p[k] & g_acc);
          p_acc = p_acc & bit_p[k];
        end
      end

      assign grp_g[gi] = g_acc;
      assign grp_p[gi] = p_acc;

      // Bit carries inside the group, expanded from the group carry-in.
      always_comb begin
        bit_c = '0;
        c_run = grp_c[gi];
        for (int k = 0; k < GW; k++) begin
          bit_c[k] = c_run;
          c_run    = bit_g[k] | (bit_p[k] & c_run);
        end
      end

      assign sum[LO +: GW] = bit_p ^ bit_c;
    end
  endgenerate

  // Group carries ripple from one group to the next.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin;
    for (int i = 0; i < NG; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
  end

  assign cout = grp_c[NG];
endmodule

module cla_mod_sub_pipe #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] MODULUS = 16'd65521,
  parameter int               GROUP   = 3
) (
  input logic               clk,
  input logic               rst,
  cla_mod_sub_pipe_if.slave bus
);
  logic             adv;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] raw_reg;
  logic             brw_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] diff_reg;

  logic [WIDTH-1:0] raw_next;
  logic             s1_cout;
  logic [WIDTH-1:0] corr_addend;
  logic [WIDTH-1:0] diff_next;
  logic             corr_cout_unused;

  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage 1: two's-complement subtraction; a missing carry out means a < b.
  cla_mod_sub_pipe_cla #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_sub (
    .x    (bus.a_in),
    .y    (~bus.b_in),
    .cin  (1'b1),
    .sum  (raw_next),
    .cout (s1_cout)
  );

  // Stage 2: add the modulus back after a borrow. The carry out of this add
  // is discarded on purpose, the wrap modulo 2**WIDTH is the intended result.
  assign corr_addend = brw_reg ? MODULUS : '0;

  cla_mod_sub_pipe_cla #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_corr (
    .x    (raw_reg),
    .y    (corr_addend),
    .cin  (1'b0),
    .sum  (diff_next),
    .cout (corr_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      raw_reg       <= '0;
      brw_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
    end else if (adv) begin
      s1_valid_reg  <= bus.in_valid;
      raw_reg       <= raw_next;
      brw_reg       <= !s1_cout;
      out_valid_reg <= s1_valid_reg;
      diff_reg      <= diff_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.diff_out  = diff_reg;

`ifdef MODSUB_RANGE_CHK_EN
  logic s1_err_reg;
  logic out_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err_reg  <= 1'b0;
      out_err_reg <= 1'b0;
    end else if (adv) begin
      s1_err_reg  <= (bus.a_in >= MODULUS) || (bus.b_in >= MODULUS);
      out_err_reg <= s1_err_reg;
    end
  end

  assign bus.out_err = out_err_reg;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_cla_mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_mod_sub_pipe
//   Self-checking bench for cla_mod_sub_pipe (WIDTH=16, MODULUS=65521).
//   A negedge monitor keeps a queue of expected results, filled from
//   (a - b) mod M computed with plain integer arithmetic on every accepted
//   pair and drained on every result transfer. Directed sequences cover
//   reset state, latency, boundary pairs, back-pressure and mid-stream reset;
//   a random block streams 1000 pairs back to back.
// -----------------------------------------------------------------------------
module tb_cla_mod_sub_pipe;
  localparam int WIDTH = 16;
  localparam int M     = 65521;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_mod_sub_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla_mod_sub_pipe #(
    .WIDTH   (WIDTH),
    .MODULUS (16'd65521),
    .GROUP   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int a;
    int b;
    int diff;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = d + M;
    return d;
  endfunction

  function automatic int ref_err(input int a, input int b);
`ifdef MODSUB_RANGE_CHK_EN
    return (a >= M || b >= M) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Scoreboard: results are checked before new pairs are queued, since the
  // result leaving this cycle is always older than the pair entering.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          $display("xfer %0d: a=%0d b=%0d diff_out=%0d out_err=%0d", n_out, e.a, e.b,
                   bus.diff_out, bus.out_err);
          if (e.err == 0) check_eq("diff_out", bus.diff_out, e.diff);
          check_eq("out_err", bus.out_err, e.err);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t n;
        n.a    = int'(bus.a_in);
        n.b    = int'(bus.b_in);
        n.diff = ref_diff(n.a, n.b);
        n.err  = ref_err(n.a, n.b);
        exp_q.push_back(n);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b);
    bus.in_valid = 1'b1;
    bus.a_in     = WIDTH'(a);
    bus.b_in     = WIDTH'(b);
    tick();
  endtask

  task automatic drain(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  int   out_base;
  logic [WIDTH-1:0] snap;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_diff_out", bus.diff_out, 0);
    check_eq("rst_out_err", bus.out_err, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Latency: pair presented in one cycle, result visible two cycles later
    send(10, 3);
    bus.in_valid = 1'b0;
    check_eq("lat_cycle1_valid", bus.out_valid, 0);
    tick();
    check_eq("lat_cycle2_valid", bus.out_valid, 1);
    check_eq("lat_cycle2_diff", bus.diff_out, 7);
    tick();
    check_eq("lat_cycle3_valid", bus.out_valid, 0);

    // Boundary pairs, back to back
    send(3, 10);
    send(0, M - 1);
    send(40000, 40000);
    send(M - 1, 0);
    send(0, 0);
    send(M - 1, M - 1);
    drain(4);
    check_eq("boundary_drained", exp_q.size(), 0);

    // 1000 random pairs back to back with out_ready held high
    out_base = n_out;
    for (int i = 0; i < 1000; i++) begin
      int a;
      int b;
      a = $urandom_range(M - 1);
      b = $urandom_range(M - 1);
      check_eq("rand_in_ready", bus.in_ready, 1);
      send(a, b);
      if (i >= 1) check_eq("rand_throughput", bus.out_valid, 1);
    end
    drain(4);
    check_eq("rand_count", n_out - out_base, 1000);
    check_eq("rand_drained", exp_q.size(), 0);

    // Back-pressure with a full pipe
    for (int i = 0; i < 4; i++) send($urandom_range(M - 1), $urandom_range(M - 1));
    bus.a_in      = 16'd1234;
    bus.b_in      = 16'd4321;
    bus.out_ready = 1'b0;
    #1;
    check_eq("stall_in_ready", bus.in_ready, 0);
    snap = bus.diff_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_in_ready", bus.in_ready, 0);
      check_eq("stall_out_valid", bus.out_valid, 1);
      check_eq("stall_diff_hold", bus.diff_out, snap);
    end
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send($urandom_range(M - 1), $urandom_range(M - 1));
    drain(4);
    check_eq("stall_drained", exp_q.size(), 0);

    // Reset with two pairs in flight
    bus.out_ready = 1'b0;
    send(500, 100);
    send(7, 9);
    bus.in_valid = 1'b0;
    check_eq("inflight_valid", bus.out_valid, 1);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_diff_out", bus.diff_out, 0);
    check_eq("midrst_out_err", bus.out_err, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("midrst_no_output", bus.out_valid, 0);
    end

`ifdef MODSUB_RANGE_CHK_EN
    // Range flag travels with its result
    send(M, 0);
    send(M - 1, M - 1);
    send(65535, 7);
    send(12, 65530);
    send(100, 50);
    drain(4);
    check_eq("range_drained", exp_q.size(), 0);
`endif

    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
